axi3_led_slave_m: RTL and testbench
===================================

Name: axi3_led_slave_m

Overview:
- AXI3 slave register block that terminates one PS7 general-purpose master port (GP0 or GP1) inside the PL.
- Exposes an LED register, a scratch register, a free-running cycle counter and a constant ID word to software.
- Sits between ps7_m and the board LEDs.
- Responds to single and burst transactions.
- Supports one outstanding write and one outstanding read, processed concurrently.

Parameters:
ID_W, 12, width of all AXI ID fields
ADDR_W, 32, AXI address width
LED_W, 8, number of LED outputs (1..32)
ID_VALUE, 32'h4C454438, constant returned at offset 0x0C

Ports:
i_clk  in  1  AXI clock (FCLK_CLK0)
i_rst  in  1  reset, asynchronous, active-high
i_aw_valid, o_aw_ready  in/out  1 each  AW handshake
i_aw_id, i_aw_addr, i_aw_len, i_aw_size, i_aw_burst  in  ID_W, ADDR_W, 4, 3, 2  AW payload
i_w_valid, o_w_ready  in/out  1 each  W handshake
i_w_id, i_w_data, i_w_strb, i_w_last  in  ID_W, 32, 4, 1  W payload (i_w_id ignored)
o_b_valid, i_b_ready  out/in  1 each  B handshake
o_b_id, o_b_resp  out  ID_W, 2  B payload
i_ar_valid, o_ar_ready  in/out  1 each  AR handshake
i_ar_id, i_ar_addr, i_ar_len, i_ar_size, i_ar_burst  in  ID_W, ADDR_W, 4, 3, 2  AR payload
o_r_valid, i_r_ready  out/in  1 each  R handshake
o_r_id, o_r_data, o_r_resp, o_r_last  out  ID_W, 32, 2, 1  R payload
o_led  out  LED_W  LED register bits [LED_W-1:0]

Behaviour:
- Register map: word index = addr[3:2]; upper address bits ignored, so the map aliases every 16 B.
  - 0 LED: RW, LED_W bits, upper bits read 0.
  - 1 SCRATCH: RW, 32 bits.
  - 2 CYCLES: RO, 32-bit counter.
  - 3 ID: RO, ID_VALUE.
- Reset: all registers, the counter and every o_*valid are 0; o_aw_ready and o_ar_ready are 1; o_led is 0; all other outputs are 0. Reset asserted mid-burst aborts the burst with no response.
- CYCLES increments by 1 every cycle out of reset and wraps from 0xFFFFFFFF to 0.
- Write FSM: W_IDLE -> W_DATA -> W_RESP.
  - W_IDLE: o_aw_ready=1. AW handshake latches id, word index, len, burst, and err = (size!=2); goes to W_DATA.
  - W_DATA: o_w_ready=1. Each accepted beat writes the addressed register using i_w_strb per byte, unless err is set or the target is RO.
  - Index advance per beat: INCR and WRAP add 1 modulo 4; FIXED holds the index.
  - Beat count is decoupled from i_w_last. The burst ends on the beat where i_w_last=1 or the count reaches len+1, whichever comes first.
  - W_RESP: o_b_valid is asserted the cycle after the last beat. b_resp = SLVERR(2'b10) if err or any beat targeted an RO register, else OKAY. o_b_id = latched AW id.
  - On the B handshake, return to W_IDLE, which re-asserts o_aw_ready the next cycle.
- Read FSM: R_IDLE -> R_DATA.
  - R_IDLE: o_ar_ready=1. AR handshake latches payload.
  - o_r_valid is asserted the cycle after AR acceptance with beat 0 registered.
  - o_r_data for each beat is sampled the cycle that beat is loaded. CYCLES therefore reflects load time. Data is held stable while o_r_valid && !i_r_ready.
  - o_r_last=1 on beat len.
  - r_resp = SLVERR with data 0 if size!=2, else OKAY.
  - After the last handshake, return to R_IDLE.
- Back-to-back beats: with i_r_ready held high, one beat per cycle.
- Concurrent read/write of the same register in the same cycle: the read returns the pre-write value.
- o_led is a direct register output; it updates the cycle after the accepting W beat.

Test Plan:
- Single write 0xA5 with strb 4'b0001 to 0x00, then read 0x00 -> o_led = 8'hA5 one cycle after W; B OKAY with matching id 0x123; read data 0x000000A5.
- INCR burst len=3 at 0x00 writing 0x1,0x2,0x3,0x4 -> LED=0x01, SCRATCH=0x2; beats to CYCLES and ID are ignored; single B with SLVERR.
- Read INCR len=3 from 0x00 with i_r_ready held low for 3 cycles on beat 1 -> 4 beats returned; data stable while stalled; o_r_last only on beat 3; second CYCLES read of a pair differs by at least the stall.
- AW with size=1 writing 0xFF to LED -> LED unchanged; B SLVERR. AR with size=0 -> r_resp SLVERR, data 0.
- FIXED read len=2 at 0x0C -> three beats of 0x4C454438.
- Assert i_rst during W_DATA after 2 of 4 beats -> all valids 0, o_led 0, o_aw_ready 1 one cycle after deassertion; a fresh write then completes normally.

Source files
------------

// File: rtl/axi3_led_slave_m.sv
// +----------------------------------------------------------------------------+
// | Module : axi3_led_slave_m                                                  |
// | Brief  : AXI3 slave register block (LED, scratch, cycle counter, ID word)  |
// |          terminating one PS7 GP master port; one write and one read in     |
// |          flight at a time, handled concurrently.                           |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module axi3_led_slave_m #(
  parameter int          ID_W     = 12,
  parameter int          ADDR_W   = 32,
  parameter int          LED_W    = 8,
  parameter logic [31:0] ID_VALUE = 32'h4C454438
) (
  input  logic              i_clk,
  input  logic              i_rst,
  // write address
  input  logic              i_aw_valid,
  output logic              o_aw_ready,
  input  logic [ID_W-1:0]   i_aw_id,
  input  logic [ADDR_W-1:0] i_aw_addr,
  input  logic [3:0]        i_aw_len,
  input  logic [2:0]        i_aw_size,
  input  logic [1:0]        i_aw_burst,
  // write data
  input  logic              i_w_valid,
  output logic              o_w_ready,
  input  logic [ID_W-1:0]   i_w_id,
  input  logic [31:0]       i_w_data,
  input  logic [3:0]        i_w_strb,
  input  logic              i_w_last,
  // write response
  output logic              o_b_valid,
  input  logic              i_b_ready,
  output logic [ID_W-1:0]   o_b_id,
  output logic [1:0]        o_b_resp,
  // read address
  input  logic              i_ar_valid,
  output logic              o_ar_ready,
  input  logic [ID_W-1:0]   i_ar_id,
  input  logic [ADDR_W-1:0] i_ar_addr,
  input  logic [3:0]        i_ar_len,
  input  logic [2:0]        i_ar_size,
  input  logic [1:0]        i_ar_burst,
  // read data
  output logic              o_r_valid,
  input  logic              i_r_ready,
  output logic [ID_W-1:0]   o_r_id,
  output logic [31:0]       o_r_data,
  output logic [1:0]        o_r_resp,
  output logic              o_r_last,
  // board LEDs
  output logic [LED_W-1:0]  o_led
);

  localparam logic [1:0] c_RESP_OKAY   = 2'b00;
  localparam logic [1:0] c_RESP_SLVERR = 2'b10;
  localparam logic [1:0] c_BURST_FIXED = 2'b00;
  localparam logic [2:0] c_SIZE_WORD   = 3'd2;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  // register file
  logic [LED_W-1:0] r_led;
  logic [31:0]      r_scratch;
  logic [31:0]      r_cycles;

  // write channel state
  w_state_t         r_wstate;
  logic [ID_W-1:0]  r_wid;
  logic [1:0]       r_widx;
  logic [3:0]       r_wlen;
  logic [3:0]       r_wcnt;
  logic [1:0]       r_wburst;
  logic             r_werr;
  logic             r_wro;
  logic             r_aw_ready;
  logic             r_w_ready;
  logic             r_b_valid;
  logic [1:0]       r_b_resp;

  // read channel state
  r_state_t         r_rstate;
  logic [ID_W-1:0]  r_rid;
  logic [1:0]       r_ridx;
  logic [3:0]       r_rlen;
  logic [3:0]       r_rcnt;
  logic [1:0]       r_rburst;
  logic             r_rerr;
  logic             r_ar_ready;
  logic             r_r_valid;
  logic             r_r_last;
  logic [31:0]      r_r_data;
  logic [1:0]       r_r_resp;

  logic [1:0]       w_widx_next;
  logic             w_beat_ro;
  logic             w_wlast_beat;
  logic [1:0]       w_ridx_next;
  logic [1:0]       w_rd_idx;
  logic             w_rd_err;
  logic [31:0]      w_led_ext;
  logic [31:0]      w_rd_word;
  logic [31:0]      w_scratch_new;
  logic             w_unused;

  // Address bits outside the word index and the W-channel ID carry no meaning here.
  assign w_unused = ^{i_w_id, i_aw_addr[ADDR_W-1:4], i_aw_addr[1:0],
                      i_ar_addr[ADDR_W-1:4], i_ar_addr[1:0]};

  // Word index 2 and 3 (CYCLES, ID) are read-only.
  assign w_beat_ro    = r_widx[1];
  assign w_widx_next  = (r_wburst == c_BURST_FIXED) ? r_widx : r_widx + 2'd1;
  assign w_wlast_beat = i_w_last || (r_wcnt == r_wlen);
  assign w_ridx_next  = (r_rburst == c_BURST_FIXED) ? r_ridx : r_ridx + 2'd1;

  // Beat 0 is loaded on the AR handshake, later beats on each R handshake.
  assign w_rd_idx = (r_rstate == R_IDLE) ? i_ar_addr[3:2] : w_ridx_next;
  assign w_rd_err = (r_rstate == R_IDLE) ? (i_ar_size != c_SIZE_WORD) : r_rerr;

  // Byte-strobed merge of write data into the scratch register.
  always_comb begin
    w_scratch_new = r_scratch;
    for (int b = 0; b < 4; b++) begin
      if (i_w_strb[b]) w_scratch_new[b*8 +: 8] = i_w_data[b*8 +: 8];
    end
  end

  // Read mux over the register map; LED upper bits read as zero.
  always_comb begin
    w_led_ext              = '0;
    w_led_ext[LED_W-1:0]   = r_led;
    unique case (w_rd_idx)
      2'd0:    w_rd_word = w_led_ext;
      2'd1:    w_rd_word = r_scratch;
      2'd2:    w_rd_word = r_cycles;
      default: w_rd_word = ID_VALUE;
    endcase
  end

  // Free-running cycle counter, wraps naturally.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_cycles <= '0;
    else       r_cycles <= r_cycles + 32'd1;
  end

  // Write FSM together with the writable registers it owns.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wstate   <= W_IDLE;
      r_wid      <= '0;
      r_widx     <= '0;
      r_wlen     <= '0;
      r_wcnt     <= '0;
      r_wburst   <= '0;
      r_werr     <= 1'b0;
      r_wro      <= 1'b0;
      r_aw_ready <= 1'b1;
      r_w_ready  <= 1'b0;
      r_b_valid  <= 1'b0;
      r_b_resp   <= c_RESP_OKAY;
      r_led      <= '0;
      r_scratch  <= '0;
    end else begin
      unique case (r_wstate)
        W_IDLE: begin
          if (i_aw_valid) begin
            r_wid      <= i_aw_id;
            r_widx     <= i_aw_addr[3:2];
            r_wlen     <= i_aw_len;
            r_wburst   <= i_aw_burst;
            r_werr     <= (i_aw_size != c_SIZE_WORD);
            r_wro      <= 1'b0;
            r_wcnt     <= '0;
            r_aw_ready <= 1'b0;
            r_w_ready  <= 1'b1;
            r_wstate   <= W_DATA;
          end
        end
        W_DATA: begin
          if (i_w_valid) begin
            if (!r_werr) begin
              if (r_widx == 2'd0) begin
                for (int b = 0; b < LED_W; b++) begin
                  if (i_w_strb[b/8]) r_led[b] <= i_w_data[b];
                end
              end else if (r_widx == 2'd1) begin
                r_scratch <= w_scratch_new;
              end
            end
            if (w_wlast_beat) begin
              r_w_ready <= 1'b0;
              r_b_valid <= 1'b1;
              r_b_resp  <= (r_werr || r_wro || w_beat_ro) ? c_RESP_SLVERR : c_RESP_OKAY;
              r_wstate  <= W_RESP;
            end else begin
              r_wcnt <= r_wcnt + 4'd1;
              r_widx <= w_widx_next;
              r_wro  <= r_wro | w_beat_ro;
            end
          end
        end
        W_RESP: begin
          if (i_b_ready) begin
            r_b_valid  <= 1'b0;
            r_aw_ready <= 1'b1;
            r_wstate   <= W_IDLE;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  // Read FSM: registers each beat's data at load time and holds it through stalls.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rstate   <= R_IDLE;
      r_rid      <= '0;
      r_ridx     <= '0;
      r_rlen     <= '0;
      r_rcnt     <= '0;
      r_rburst   <= '0;
      r_rerr     <= 1'b0;
      r_ar_ready <= 1'b1;
      r_r_valid  <= 1'b0;
      r_r_last   <= 1'b0;
      r_r_data   <= '0;
      r_r_resp   <= c_RESP_OKAY;
    end else begin
      unique case (r_rstate)
        R_IDLE: begin
          if (i_ar_valid) begin
            r_rid      <= i_ar_id;
            r_ridx     <= i_ar_addr[3:2];
            r_rlen     <= i_ar_len;
            r_rburst   <= i_ar_burst;
            r_rerr     <= w_rd_err;
            r_rcnt     <= '0;
            r_ar_ready <= 1'b0;
            r_r_valid  <= 1'b1;
            r_r_data   <= w_rd_err ? 32'd0 : w_rd_word;
            r_r_resp   <= w_rd_err ? c_RESP_SLVERR : c_RESP_OKAY;
            r_r_last   <= (i_ar_len == 4'd0);
            r_rstate   <= R_DATA;
          end
        end
        R_DATA: begin
          if (i_r_ready) begin
            if (r_r_last) begin
              r_r_valid  <= 1'b0;
              r_r_last   <= 1'b0;
              r_r_data   <= '0;
              r_r_resp   <= c_RESP_OKAY;
              r_ar_ready <= 1'b1;
              r_rstate   <= R_IDLE;
            end else begin
              r_ridx   <= w_ridx_next;
              r_rcnt   <= r_rcnt + 4'd1;
              r_r_data <= w_rd_err ? 32'd0 : w_rd_word;
              r_r_last <= ((r_rcnt + 4'd1) == r_rlen);
            end
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  assign o_aw_ready = r_aw_ready;
  assign o_w_ready  = r_w_ready;
  assign o_b_valid  = r_b_valid;
  assign o_b_id     = r_wid;
  assign o_b_resp   = r_b_resp;
  assign o_ar_ready = r_ar_ready;
  assign o_r_valid  = r_r_valid;
  assign o_r_id     = r_rid;
  assign o_r_data   = r_r_data;
  assign o_r_resp   = r_r_resp;
  assign o_r_last   = r_r_last;
  assign o_led      = r_led;

endmodule

`default_nettype wire

// File: tb/tb_axi3_led_slave_m.sv
// +----------------------------------------------------------------------------+
// | Module : tb_axi3_led_slave_m                                               |
// | Brief  : Self-checking bench for axi3_led_slave_m: directed cases followed |
// |          by random transactions against a register-map reference model.    |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_axi3_led_slave_m;

  localparam int          ID_W     = 12;
  localparam int          ADDR_W   = 32;
  localparam int          LED_W    = 8;
  localparam logic [31:0] ID_VALUE = 32'h4C454438;
  localparam logic [31:0] LED_MASK = 32'h000000FF;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              aw_valid, aw_ready, w_valid, w_ready, w_last, b_valid, b_ready;
  logic [ID_W-1:0]   aw_id, w_id, b_id, ar_id, r_id;
  logic [ADDR_W-1:0] aw_addr, ar_addr;
  logic [3:0]        aw_len, ar_len, w_strb;
  logic [2:0]        aw_size, ar_size;
  logic [1:0]        aw_burst, ar_burst, b_resp, r_resp;
  logic [31:0]       w_data, r_data;
  logic              ar_valid, ar_ready, r_valid, r_ready, r_last;
  logic [LED_W-1:0]  led;

  always #5 clk = ~clk;

  axi3_led_slave_m #(.ID_W(ID_W), .ADDR_W(ADDR_W), .LED_W(LED_W), .ID_VALUE(ID_VALUE)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_aw_valid(aw_valid), .o_aw_ready(aw_ready), .i_aw_id(aw_id), .i_aw_addr(aw_addr),
    .i_aw_len(aw_len), .i_aw_size(aw_size), .i_aw_burst(aw_burst),
    .i_w_valid(w_valid), .o_w_ready(w_ready), .i_w_id(w_id), .i_w_data(w_data),
    .i_w_strb(w_strb), .i_w_last(w_last),
    .o_b_valid(b_valid), .i_b_ready(b_ready), .o_b_id(b_id), .o_b_resp(b_resp),
    .i_ar_valid(ar_valid), .o_ar_ready(ar_ready), .i_ar_id(ar_id), .i_ar_addr(ar_addr),
    .i_ar_len(ar_len), .i_ar_size(ar_size), .i_ar_burst(ar_burst),
    .o_r_valid(r_valid), .i_r_ready(r_ready), .o_r_id(r_id), .o_r_data(r_data),
    .o_r_resp(r_resp), .o_r_last(r_last),
    .o_led(led)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] tb_cyc;          // clock edges seen since reset release
  logic [31:0] m_led;           // reference LED value (zero-extended)
  logic [31:0] m_scratch;       // reference scratch value
  logic [31:0] wd [16];
  logic [3:0]  ws [16];

  // Reference count of clock edges out of reset.
  always @(posedge clk or posedge rst) begin
    if (rst) tb_cyc <= 32'd0;
    else     tb_cyc <= tb_cyc + 32'd1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] f_strb(input logic [31:0] o, input logic [31:0] d,
                                         input logic [3:0] s);
    f_strb = o;
    for (int b = 0; b < 4; b++) if (s[b]) f_strb[b*8 +: 8] = d[b*8 +: 8];
  endfunction

  function automatic logic [31:0] m_word(input logic [1:0] idx, input logic [31:0] cyc);
    case (idx)
      2'd0:    m_word = m_led;
      2'd1:    m_word = m_scratch;
      2'd2:    m_word = cyc;
      default: m_word = ID_VALUE;
    endcase
  endfunction

  // Wait (bounded) at falling edges until sig is high.
  task automatic wait_hi(input string tag, ref logic sig);
    int t = 0;
    while (sig !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    chk(tag, 32'(sig), 32'd1);
  endtask

  task automatic do_write(input logic [ID_W-1:0] id, input logic [31:0] addr,
                          input logic [3:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input int nbeats, input bit use_last);
    logic [1:0] idx = addr[3:2];
    bit         err = (size != 3'd2);
    bit         ro  = 1'b0;
    @(negedge clk);
    aw_valid = 1'b1; aw_id = id; aw_addr = addr; aw_len = len; aw_size = size; aw_burst = burst;
    wait_hi("aw_ready", aw_ready);
    @(negedge clk);
    aw_valid = 1'b0;
    for (int k = 0; k < nbeats; k++) begin
      w_valid = 1'b1; w_data = wd[k]; w_strb = ws[k];
      w_last  = use_last && (k == nbeats - 1);
      wait_hi("w_ready", w_ready);
      @(negedge clk);
      if (idx >= 2'd2) ro = 1'b1;
      else if (!err) begin
        if (idx == 2'd0) m_led = f_strb(m_led, wd[k], ws[k]) & LED_MASK;
        else             m_scratch = f_strb(m_scratch, wd[k], ws[k]);
      end
      if (burst != 2'b00) idx = idx + 2'd1;
      chk("led_after_beat", 32'(led), m_led);
    end
    w_valid = 1'b0; w_last = 1'b0;
    chk("w_ready_low", 32'(w_ready), 32'd0);
    chk("b_valid", 32'(b_valid), 32'd1);
    chk("b_resp", 32'(b_resp), (err || ro) ? 32'd2 : 32'd0);
    chk("b_id", 32'(b_id), 32'(id));
    repeat ($urandom_range(0, 2)) @(negedge clk);
    b_ready = 1'b1;
    @(negedge clk);
    b_ready = 1'b0;
    chk("b_valid_done", 32'(b_valid), 32'd0);
    chk("aw_ready_back", 32'(aw_ready), 32'd1);
  endtask

  task automatic do_read(input logic [ID_W-1:0] id, input logic [31:0] addr,
                         input logic [3:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input int stall_beat, input int stall_len);
    logic [1:0]  idx = addr[3:2];
    bit          err = (size != 3'd2);
    logic [31:0] cyc_load;
    logic [31:0] exp;
    int          s;
    @(negedge clk);
    ar_valid = 1'b1; ar_id = id; ar_addr = addr; ar_len = len; ar_size = size; ar_burst = burst;
    wait_hi("ar_ready", ar_ready);
    cyc_load = tb_cyc;
    @(negedge clk);
    ar_valid = 1'b0;
    for (int k = 0; k <= int'(len); k++) begin
      exp = err ? 32'd0 : m_word(idx, cyc_load);
      s   = (k == stall_beat) ? stall_len : int'($urandom_range(0, 1));
      r_ready = 1'b0;
      for (int j = 0; j <= s; j++) begin
        chk("r_valid", 32'(r_valid), 32'd1);
        chk("r_data", r_data, exp);
        chk("r_last", 32'(r_last), (k == int'(len)) ? 32'd1 : 32'd0);
        chk("r_resp", 32'(r_resp), err ? 32'd2 : 32'd0);
        chk("r_id", 32'(r_id), 32'(id));
        if (j < s) @(negedge clk);
      end
      r_ready  = 1'b1;
      cyc_load = tb_cyc;
      @(negedge clk);
      r_ready  = 1'b0;
      if (burst != 2'b00) idx = idx + 2'd1;
    end
    chk("r_valid_done", 32'(r_valid), 32'd0);
    chk("ar_ready_back", 32'(ar_ready), 32'd1);
  endtask

  initial begin
    logic [3:0] len;
    int         nb;
    bit         ul;
    aw_valid = 0; aw_id = '0; aw_addr = '0; aw_len = '0; aw_size = '0; aw_burst = '0;
    w_valid = 0; w_id = '0; w_data = '0; w_strb = '0; w_last = 0; b_ready = 0;
    ar_valid = 0; ar_id = '0; ar_addr = '0; ar_len = '0; ar_size = '0; ar_burst = '0;
    r_ready = 0;
    m_led = 32'd0; m_scratch = 32'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_aw_ready", 32'(aw_ready), 32'd1);
    chk("rst_ar_ready", 32'(ar_ready), 32'd1);
    chk("rst_w_ready", 32'(w_ready), 32'd0);
    chk("rst_b_valid", 32'(b_valid), 32'd0);
    chk("rst_r_valid", 32'(r_valid), 32'd0);
    chk("rst_led", 32'(led), 32'd0);
    chk("rst_r_data", r_data, 32'd0);

    // Single write 0xA5 to LED then read back
    wd[0] = 32'h000000A5; ws[0] = 4'b0001;
    do_write(12'h123, 32'h0, 4'd0, 3'd2, 2'b01, 1, 1'b1);
    chk("led_a5", 32'(led), 32'hA5);
    do_read(12'h123, 32'h0, 4'd0, 3'd2, 2'b01, -1, 0);

    // INCR len=3 across the whole map: LED, SCRATCH written; RO beats -> SLVERR
    for (int k = 0; k < 4; k++) begin wd[k] = 32'(k + 1); ws[k] = 4'hF; end
    do_write(12'h0AB, 32'h0, 4'd3, 3'd2, 2'b01, 4, 1'b1);
    chk("led_incr", 32'(led), 32'h01);
    chk("scratch_model", m_scratch, 32'h2);

    // INCR read len=3 with a 3-cycle stall on beat 1
    do_read(12'h055, 32'h0, 4'd3, 3'd2, 2'b01, 1, 3);

    // Narrow write (size=1) must not touch LED; narrow read returns SLVERR/0
    wd[0] = 32'hFF; ws[0] = 4'hF;
    do_write(12'h011, 32'h0, 4'd0, 3'd1, 2'b01, 1, 1'b1);
    chk("led_unchanged", 32'(led), 32'h01);
    do_read(12'h022, 32'h0, 4'd0, 3'd0, 2'b01, -1, 0);

    // FIXED read len=2 at the ID register
    do_read(12'h333, 32'h0000000C, 4'd2, 3'd2, 2'b00, -1, 0);

    // Reset in the middle of a 4-beat write burst
    @(negedge clk);
    aw_valid = 1'b1; aw_id = 12'h777; aw_addr = 32'h0; aw_len = 4'd3; aw_size = 3'd2; aw_burst = 2'b01;
    wait_hi("mid_aw_ready", aw_ready);
    @(negedge clk);
    aw_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      w_valid = 1'b1; w_data = 32'h5A + 32'(k); w_strb = 4'hF; w_last = 1'b0;
      wait_hi("mid_w_ready", w_ready);
      @(negedge clk);
    end
    w_valid = 1'b0;
    chk("mid_led", 32'(led), 32'h5A);
    rst = 1'b1;
    m_led = 32'd0; m_scratch = 32'd0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_aw_ready", 32'(aw_ready), 32'd1);
    chk("abort_w_ready", 32'(w_ready), 32'd0);
    chk("abort_b_valid", 32'(b_valid), 32'd0);
    chk("abort_r_valid", 32'(r_valid), 32'd0);
    chk("abort_led", 32'(led), 32'd0);
    wd[0] = 32'h3C; ws[0] = 4'hF; wd[1] = 32'hDEADBEEF; ws[1] = 4'b1010;
    do_write(12'h778, 32'h0, 4'd1, 3'd2, 2'b01, 2, 1'b1);
    do_read(12'h779, 32'h0, 4'd1, 3'd2, 2'b01, -1, 0);

    // Random transactions against the reference model
    repeat (40) begin
      len = 4'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) begin
        nb = int'($urandom_range(1, int'(len) + 1));
        ul = (nb < int'(len) + 1) ? 1'b1 : 1'($urandom_range(0, 1));
        for (int k = 0; k < 16; k++) begin wd[k] = $urandom; ws[k] = 4'($urandom); end
        do_write(ID_W'($urandom), $urandom, len,
                 ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 1)) : 3'd2,
                 2'($urandom_range(0, 2)), nb, ul);
      end else begin
        do_read(ID_W'($urandom), $urandom, len,
                ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 1)) : 3'd2,
                2'($urandom_range(0, 2)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
